// File: rtl/hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_unit_pkg
// Shared CPU pipeline constants used by hazard_unit:
//   - hz_state_e : hazard-control FSM state encodings (RUN/MEM_WAIT/ERR)
//   - fwd_sel_e  : operand forwarding select encodings (00/01/10)
//   - register-address and wait-counter widths
// -----------------------------------------------------------------------------
package hazard_unit_pkg;

    // Architectural register address width (x0..x31).
    localparam int REG_ADDR_W = 5;

    // Wide enough for the largest legal MEM_TIMEOUT (65535).
    localparam int WAIT_CNT_W = 16;

    // Hazard-control FSM. HZ_RSVD is never entered; it decodes back to RUN.
    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_ERR      = 2'd2,
        HZ_RSVD     = 2'd3
    } hz_state_e;

    // Forwarding mux selects shared with the forwarding unit.
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,   // operand from register file
        FWD_MEM  = 2'b01,   // operand from EX/MEM result
        FWD_WB   = 2'b10    // operand from MEM/WB result
    } fwd_sel_e;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   : clock, rising-edge
//   rst   : asynchronous active-high reset, clears the count
//   inc   : add one on this edge (ignored once saturated)
//   clr   : synchronous clear, takes priority over inc
//   count : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_max;

    assign at_max = &count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !at_max) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard controller for a 5-stage in-order core. Decides each cycle
// whether to stall or flush pipeline registers, based on:
//   - data-memory back-pressure (freeze the whole pipe while MEM waits),
//   - taken branches resolved in EX (flush the two younger instructions),
//   - load-use dependencies (insert one bubble behind a load).
// A small FSM tracks outstanding memory waits and escalates to a sticky
// error state when memory fails to answer within MEM_TIMEOUT cycles.
//
// Parameters:
//   MEM_TIMEOUT : max consecutive MEM_WAIT cycles before ERR (1..65535)
//   CNT_W       : width of the stall_cycles performance counter
// Ports:
//   clk, rst               : clock, async active-high reset
//   id_rs1, id_rs2         : ID-stage source registers
//   id_uses_rs1/2          : ID instruction really reads rs1/rs2
//   ex_rd, ex_MemRead      : EX-stage destination and load flag
//   ex_branch_taken        : EX redirect
//   mem_req, mem_ready     : MEM-stage data-memory handshake
//   stall_f/d/e            : hold PC+IF/ID, ID/EX, EX/MEM
//   flush_d/e/m            : bubble IF/ID, ID/EX, MEM/WB
//   mem_timeout            : high while in ERR
//   hz_state               : current FSM encoding
//   stall_cycles           : saturating count of edges with stall_f high
// -----------------------------------------------------------------------------
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int          CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_MemRead,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  flush_m,
    output logic                  mem_timeout,
    output logic [1:0]            hz_state,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic [WAIT_CNT_W:0] TIMEOUT_LIM = (WAIT_CNT_W+1)'(MEM_TIMEOUT);

    hz_state_e             state_q;
    hz_state_e             state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_d;
    logic [WAIT_CNT_W:0]   wait_inc;

    logic mem_stall;
    logic freeze;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    // ---------------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------------
    assign mem_stall = mem_req && !mem_ready;

    // ERR freezes unconditionally; RUN/MEM_WAIT freeze only while memory is
    // holding off an access. The reserved encoding never freezes.
    assign freeze = (((state_q == HZ_RUN) || (state_q == HZ_MEM_WAIT)) && mem_stall)
                    || (state_q == HZ_ERR);

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign rs1_hit  = id_uses_rs1 && (ex_rd == id_rs1);
    assign rs2_hit  = id_uses_rs2 && (ex_rd == id_rs2);
    assign load_use = ex_MemRead && (ex_rd != '0) && (rs1_hit || rs2_hit);

    // ---------------------------------------------------------------------
    // Stall / flush decode (combinational, same-cycle)
    // ---------------------------------------------------------------------
    // A branch sitting in a frozen EX keeps ex_branch_taken asserted, so its
    // flush naturally fires on the first cycle the freeze lifts.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (rst) begin
            // Everything stays quiet while reset is held.
        end else if (freeze) begin
            // Hold IF..EX in place and keep a bubble flowing into WB so the
            // stalled MEM instruction is not retired twice.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (ex_branch_taken) begin
            // Both younger instructions are on the wrong path; any load-use
            // they raised is moot.
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            // Keep the consumer in ID one cycle and send a bubble to EX; the
            // load moves on to MEM on the next edge, so one bubble suffices.
            stall_f = 1'b1;
            flush_e = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Memory-wait FSM
    // ---------------------------------------------------------------------
    assign wait_inc = {1'b0, wait_cnt_q} + {{WAIT_CNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            HZ_RUN: begin
                if (mem_stall) begin
                    state_d    = HZ_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            HZ_MEM_WAIT: begin
                if (mem_ready || !mem_req) begin
                    // Access completed (or was withdrawn): resume.
                    state_d = HZ_RUN;
                end else begin
                    wait_cnt_d = wait_inc[WAIT_CNT_W-1:0];
                    if (wait_inc >= TIMEOUT_LIM) begin
                        state_d = HZ_ERR;
                    end
                end
            end
            HZ_ERR: begin
                // Absorbing until reset.
                state_d = HZ_ERR;
            end
            default: begin
                state_d    = HZ_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HZ_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign mem_timeout = (state_q == HZ_ERR);
    assign hz_state    = state_q;

    // ---------------------------------------------------------------------
    // Performance counter
    // ---------------------------------------------------------------------
    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_f),
        .clr   (1'b0),
        .count (stall_cycles)
    );

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum consecutive MEM_WAIT cycles before ERR; legal range 1..65535.
REQ-002 Parameter CNT_W, default 32: width of the stall_cycles performance counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rs1, id_uses_rs2  input  1 each  ID instruction actually reads rs1 / rs2.
REQ-007 ex_rd  input  5  destination of the instruction in EX.
REQ-008 ex_MemRead  input  1  EX instruction is a load.
REQ-009 ex_branch_taken  input  1  branch/jump resolved taken in EX (redirect).
REQ-010 mem_req  input  1  MEM-stage instruction is issuing a data-memory access.
REQ-011 mem_ready  input  1  data memory accepts/completes the access this cycle.
REQ-012 stall_f  output  1  hold PC and IF/ID.
REQ-013 stall_d  output  1  hold ID/EX.
REQ-014 stall_e  output  1  hold EX/MEM.
REQ-015 flush_d  output  1  clear IF/ID to NOP.
REQ-016 flush_e  output  1  clear ID/EX control to bubble.
REQ-017 flush_m  output  1  clear MEM/WB control to bubble.
REQ-018 mem_timeout  output  1  sticky error: memory never answered.
REQ-019 hz_state  output  2  current FSM state encoding.
REQ-020 stall_cycles  output  CNT_W  saturating count of stalled cycles.

Function
REQ-021 FSM states SHALL be RUN=0, MEM_WAIT=1, ERR=2; encoding 3 is unreachable and SHALL transition to RUN.
REQ-022 freeze SHALL be (state is RUN or MEM_WAIT) and mem_req and not mem_ready, or state is ERR.
REQ-023 RUN -> MEM_WAIT when mem_req and not mem_ready; MEM_WAIT -> RUN on the first cycle with mem_ready high (that cycle is not frozen).
REQ-024 wait_cnt SHALL clear on entering MEM_WAIT and increment each MEM_WAIT cycle without mem_ready; when it reaches MEM_TIMEOUT, the next state is ERR.
REQ-025 ERR SHALL be absorbing until reset; mem_timeout is high exactly while in ERR.
REQ-026 load_use SHALL be ex_MemRead and ex_rd != 0 and ((id_uses_rs1 and ex_rd == id_rs1) or (id_uses_rs2 and ex_rd == id_rs2)).
REQ-027 Priority 1, freeze: stall_f=stall_d=stall_e=1, flush_m=1, flush_d=flush_e=0.
REQ-028 Priority 2, ex_branch_taken without freeze: flush_d=1, flush_e=1, all stalls 0. A simultaneous load_use is ignored.
REQ-029 Priority 3, load_use alone: stall_f=1, flush_e=1, all other outputs 0. This gives exactly one bubble, because the load leaves EX on the next edge.
REQ-030 Otherwise all stall/flush outputs SHALL be 0.
REQ-031 Stall/flush outputs SHALL be combinational from current state and inputs (same-cycle); there is no added latency.
REQ-032 A branch held in a frozen EX SHALL produce its flush on the first unfrozen cycle.
REQ-033 stall_cycles SHALL increment by 1 on every edge where stall_f is 1, and saturate at all-ones.

Reset
REQ-034 Asserting rst SHALL immediately, without a clock edge, force state=RUN, wait_cnt=0, stall_cycles=0 and mem_timeout=0.
REQ-035 While rst is high, all stall/flush outputs SHALL be 0.
REQ-036 Reset asserted mid-MEM_WAIT or in ERR SHALL abort the wait with no residual freeze after release.

Structure
REQ-037 The state encodings RUN/MEM_WAIT/ERR SHALL live in the shared CPU constants package (e.g. cpu_pkg), alongside the forwarding select encodings 00/01/10.
REQ-038 The saturating counter SHALL be one sub-module, sat_counter (parameter W; inputs inc, clr).
REQ-039 The FSM and decode SHALL remain in hazard_unit.

Verification
REQ-040 Load-use: ex_MemRead=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> stall_f=1, flush_e=1 for one cycle; stall_cycles becomes 1.
REQ-041 x0 load: ex_MemRead=1, ex_rd=0, id_rs1=0 -> all outputs 0.
REQ-042 Branch and load-use together: load-use as in REQ-040 plus ex_branch_taken=1 -> flush_d=1, flush_e=1, stall_f=0.
REQ-043 Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> freeze outputs for 3 cycles, hz_state=1 for cycles 2-3, RUN on the ready cycle; stall_cycles=3.
REQ-044 Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> hz_state=2, mem_timeout=1 and a permanent freeze; async rst pulse mid-cycle -> all outputs 0 and state RUN immediately.
REQ-045 Saturation: CNT_W=4 with 20 stalled cycles -> stall_cycles=15.
